fp16_alt_sched: RTL and testbench

Two-requester scheduler for the shared half-precision add/align datapath in the signed FP unit. It accepts operand pairs from two independent requesters over valid/ready handshakes and grants the single datapath round-robin. It registers operands, runs the combinational add/align stage, and returns the registered sign/exponent/fraction result tagged with the requester ID. It sits between the operand sources and the multiplier/normalise back end.

---
 rtl/fp16_pkg.sv | 23 ++
 rtl/fp16_alt_core.sv | 96 +++++++++
 rtl/fp16_alt_sched.sv | 125 ++++++++++++
 tb/tb_fp16_alt_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared definitions for the half-precision add/align scheduler.
// Constants, scheduler state encoding and the registered result bundle.
package fp16_pkg;

    localparam int FP16_W   = 16;
    localparam int EXP_W    = 5;
    localparam int MAN_W    = 10;
    localparam int FRAC_W   = 21;
    localparam int EXP_BIAS = 15;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_res_t;

endpackage

// File: rtl/fp16_alt_core.sv
// Combinational half-precision add/align/normalise datapath.
// Zero-exponent operands count as zero; results flush or saturate.
module fp16_alt_core
    import fp16_pkg::*;
(
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] b,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [FRAC_W-1:0] frac
);

    localparam int SUM_W = FRAC_W + 1;
    localparam int GRD_W = FRAC_W - MAN_W - 1;

    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] ma, mb;
    logic              s_big, s_small;
    logic [EXP_W-1:0]  e_big, e_small;
    logic [FRAC_W-1:0] m_big, m_small, m_shift;
    logic [SUM_W-1:0]  mag;
    logic [4:0]        lead;
    logic              found;
    logic signed [7:0] e_res;

    // Unpack operands; significand carries the hidden one and guard bits.
    always_comb begin
        sa = a[FP16_W-1];
        sb = b[FP16_W-1];
        ea = a[FP16_W-2:MAN_W];
        eb = b[FP16_W-2:MAN_W];
        ma = (ea == '0) ? '0 : {1'b1, a[MAN_W-1:0], {GRD_W{1'b0}}};
        mb = (eb == '0) ? '0 : {1'b1, b[MAN_W-1:0], {GRD_W{1'b0}}};
    end

    // Order by magnitude, align the smaller one, then add or subtract.
    always_comb begin
        if ((ea > eb) || ((ea == eb) && (ma >= mb))) begin
            s_big   = sa;
            s_small = sb;
            e_big   = ea;
            e_small = eb;
            m_big   = ma;
            m_small = mb;
        end else begin
            s_big   = sb;
            s_small = sa;
            e_big   = eb;
            e_small = ea;
            m_big   = mb;
            m_small = ma;
        end
        m_shift = m_small >> (e_big - e_small);
        if (s_big == s_small) begin
            mag = {1'b0, m_big} + {1'b0, m_shift};
        end else begin
            mag = {1'b0, m_big} - {1'b0, m_shift};
        end
    end

    // Locate the most significant set bit of the magnitude.
    always_comb begin
        lead  = '0;
        found = 1'b0;
        for (int i = 0; i < SUM_W; i++) begin
            if (mag[i]) begin
                lead  = 5'(i);
                found = 1'b1;
            end
        end
        e_res = $signed({3'b000, e_big}) + $signed({3'b000, lead}) - 8'sd20;
    end

    // Normalise so the leading one sits at the top fraction bit.
    always_comb begin
        sign = 1'b0;
        exp  = '0;
        frac = '0;
        if (!found || (e_res <= 8'sd0)) begin
            sign = 1'b0;
        end else if (e_res >= 8'sd31) begin
            sign = s_big;
            exp  = '1;
        end else begin
            sign = s_big;
            exp  = e_res[EXP_W-1:0];
            if (lead == 5'd21) begin
                frac = mag[SUM_W-1:1];
            end else begin
                frac = mag[FRAC_W-1:0] << (5'd20 - lead);
            end
        end
    end

endmodule

// File: rtl/fp16_alt_sched.sv
// Two-requester round-robin scheduler for the shared add/align datapath.
// Operands registered on accept, result registered one cycle later.
module fp16_alt_sched
    import fp16_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [15:0]       req0_a,
    input  logic [15:0]       req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [15:0]       req1_a,
    input  logic [15:0]       req1_b,
    output logic              req1_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic              res_sign,
    output logic [4:0]        res_exp,
    output logic [20:0]       res_frac,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);

    sched_state_t      state, state_next;
    logic [FP16_W-1:0] op_a, op_b;
    logic              op_id, last_id;
    logic              any_req, grant_id, accept;
    logic              res_hs;
    logic              core_sign;
    logic [EXP_W-1:0]  core_exp;
    logic [FRAC_W-1:0] core_frac;
    fp16_res_t         res_q;

    fp16_alt_core u_core (
        .a    (op_a),
        .b    (op_b),
        .sign (core_sign),
        .exp  (core_exp),
        .frac (core_frac)
    );

    assign res_hs   = res_valid && res_ready;
    assign busy     = (state != IDLE);
    assign res_sign = res_q.sign;
    assign res_exp  = res_q.exp;
    assign res_frac = res_q.frac;

    // Round-robin grant; readies never look at the payload.
    always_comb begin
        any_req    = req0_valid || req1_valid;
        grant_id   = (req0_valid && req1_valid) ? !last_id : req1_valid;
        accept     = !rst && any_req &&
                     ((state == IDLE) || ((state == DONE) && res_ready));
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
    end

    // Next-state logic; DONE with a held result waits for the consumer.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = EXEC;
            end
            EXEC: begin
                state_next = DONE;
            end
            DONE: begin
                if (accept)         state_next = EXEC;
                else if (res_ready) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand capture and arbitration history.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            op_id   <= 1'b0;
            last_id <= 1'b1;
        end else if (accept) begin
            op_a    <= grant_id ? req1_a : req0_a;
            op_b    <= grant_id ? req1_b : req0_b;
            op_id   <= grant_id;
            last_id <= grant_id;
        end
    end

    // Result register; valid drops on handshake unless a new result lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_q     <= '0;
        end else if (state == EXEC) begin
            res_valid <= 1'b1;
            res_id    <= op_id;
            res_q     <= '{sign: core_sign, exp: core_exp, frac: core_frac};
        end else if (res_hs) begin
            res_valid <= 1'b0;
        end
    end

    // Completed-handshake counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)         done_cnt <= '0;
        else if (res_hs) done_cnt <= done_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_fp16_alt_sched.sv
// Scenario bench for fp16_alt_sched with a result scoreboard.
// Expected results are queued when stimulus is driven.
module tb_fp16_alt_sched;

    typedef struct packed {
        logic        id;
        logic        sign;
        logic [4:0]  exp;
        logic [20:0] frac;
    } exp_t;

    localparam exp_t R0_TWO  = '{id: 1'b0, sign: 1'b0, exp: 5'h10, frac: 21'h100000};
    localparam exp_t R1_NEG1 = '{id: 1'b1, sign: 1'b1, exp: 5'h0F, frac: 21'h100000};
    localparam exp_t R0_ZERO = '{id: 1'b0, sign: 1'b0, exp: 5'h00, frac: 21'h000000};
    localparam exp_t R0_OVF  = '{id: 1'b0, sign: 1'b0, exp: 5'h1F, frac: 21'h000000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [15:0] req0_a = '0;
    logic [15:0] req0_b = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [15:0] req1_a = '0;
    logic [15:0] req1_b = '0;
    logic        req1_ready;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_id;
    logic        res_sign;
    logic [4:0]  res_exp;
    logic [20:0] res_frac;
    logic        busy;
    logic [15:0] done_cnt;

    exp_t got;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_done = 0;

    assign got = {res_id, res_sign, res_exp, res_frac};

    always #5 clk = ~clk;

    fp16_alt_sched #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_sign   (res_sign),
        .res_exp    (res_exp),
        .res_frac   (res_frac),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    // Requester protocol: hold valid and payload until ready.
    logic        p_rst = 1'b1;
    logic        p_v0 = 1'b0, p_r0 = 1'b0, p_v1 = 1'b0, p_r1 = 1'b0;
    logic [15:0] p_a0 = '0, p_b0 = '0, p_a1 = '0, p_b1 = '0;
    always @(posedge clk) begin
        if (!rst && !p_rst && p_v0 && !p_r0) begin
            assert (req0_valid && req0_a == p_a0 && req0_b == p_b0)
                else $error("req0 protocol rule broken");
        end
        if (!rst && !p_rst && p_v1 && !p_r1) begin
            assert (req1_valid && req1_a == p_a1 && req1_b == p_b1)
                else $error("req1 protocol rule broken");
        end
        p_rst <= rst;
        p_v0 <= req0_valid; p_r0 <= req0_ready;
        p_a0 <= req0_a;     p_b0 <= req0_b;
        p_v1 <= req1_valid; p_r1 <= req1_ready;
        p_a1 <= req1_a;     p_b1 <= req1_b;
    end

    task automatic test_reset();
        rst = 1'b1;
        req0_a = 16'h3C00; req0_b = 16'h3C00; req0_valid = 1'b1;
        req1_a = 16'h3C00; req1_b = 16'h3C00; req1_valid = 1'b1;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got r0=%b r1=%b want 0 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got v=%b busy=%b want 0 0", res_valid, busy);
        end
        checks++;
        if (got !== exp_t'(0)) begin
            errors++;
            $display("FAIL reset_result: got %h want 0", got);
        end
        checks++;
        if (done_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", done_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b v=%b want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_single_ops();
        logic [15:0] opa [3] = '{16'h3C00, 16'h3C00, 16'h7BFF};
        logic [15:0] opb [3] = '{16'h3C00, 16'hBC00, 16'h7BFF};
        exp_t        opr [3] = '{R0_TWO, R0_ZERO, R0_OVF};
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            res_ready = 1'b1;
            req0_a = opa[i]; req0_b = opb[i]; req0_valid = 1'b1;
            sb.push_back(opr[i]);
            @(negedge clk);
            checks++;
            if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL single_grant[%0d]: got r0=%b r1=%b want 1 0", i, req0_ready, req1_ready);
            end
            @(posedge clk); #1;
            req0_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_exec[%0d]: got v=%b busy=%b want 0 1", i, res_valid, busy);
            end
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (res_valid !== 1'b1 || got !== e) begin
                errors++;
                $display("FAIL single_res[%0d]: got v=%b %h want v=1 %h", i, res_valid, got, e);
            end
            exp_done++;
            @(negedge clk);
            checks++;
            if (done_cnt !== 16'(exp_done) || busy !== 1'b0 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_cnt[%0d]: got cnt=%0d busy=%b v=%b want %0d 0 0",
                         i, done_cnt, busy, res_valid, exp_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b1;
        res_ready = 1'b1;
        req0_a = 16'h3C00; req0_b = 16'h3C00; req0_valid = 1'b1;
        req1_a = 16'hC000; req1_b = 16'h3C00; req1_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_done = 0;
        sb.push_back(R0_TWO);
        sb.push_back(R1_NEG1);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tie: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_exec0: got v=%b r1=%b want 0 0", res_valid, req1_ready);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (res_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL b2b_res0: got v=%b %h want v=1 %h", res_valid, got, e);
        end
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_grant1: got r1=%b want 1", req1_ready);
        end
        exp_done++;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || done_cnt !== 16'(exp_done)) begin
            errors++;
            $display("FAIL b2b_exec1: got v=%b cnt=%0d want 0 %0d", res_valid, done_cnt, exp_done);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (res_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL b2b_res1: got v=%b %h want v=1 %h", res_valid, got, e);
        end
        exp_done++;
        @(negedge clk);
        checks++;
        if (done_cnt !== 16'(exp_done) || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got cnt=%0d busy=%b want %0d 0", done_cnt, busy, exp_done);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        @(posedge clk); #1;
        res_ready = 1'b0;
        req0_a = 16'h3C00; req0_b = 16'h3C00; req0_valid = 1'b1;
        sb.push_back(R0_TWO);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_grant0: got r0=%b want 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_a = 16'hC000; req1_b = 16'h3C00; req1_valid = 1'b1;
        sb.push_back(R1_NEG1);
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_exec: got r1=%b v=%b want 0 0", req1_ready, res_valid);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || got !== sb[0] || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b %h r1=%b want v=1 %h r1=0",
                         k, res_valid, got, req1_ready, sb[0]);
            end
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept: got r1=%b want 1", req1_ready);
        end
        e = sb.pop_front();
        checks++;
        if (res_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL stall_res0: got v=%b %h want v=1 %h", res_valid, got, e);
        end
        exp_done++;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || done_cnt !== 16'(exp_done)) begin
            errors++;
            $display("FAIL stall_gap: got v=%b cnt=%0d want 0 %0d", res_valid, done_cnt, exp_done);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (res_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL stall_res1: got v=%b %h want v=1 %h", res_valid, got, e);
        end
        exp_done++;
        @(negedge clk);
        checks++;
        if (done_cnt !== 16'(exp_done) || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_cnt: got cnt=%0d busy=%b want %0d 0", done_cnt, busy, exp_done);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(posedge clk); #1;
        res_ready = 1'b1;
        req0_a = 16'h3C00; req0_b = 16'h3C00; req0_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_grant: got r0=%b want 1", req0_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        req0_a = 16'h3C00; req0_b = 16'h3C00; req0_valid = 1'b1;
        req1_a = 16'hC000; req1_b = 16'h3C00; req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_inrst: got busy=%b r0=%b r1=%b want 1 0 0",
                     busy, req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_done = 0;
        sb.push_back(R0_TWO);
        sb.push_back(R1_NEG1);
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || got !== exp_t'(0)) begin
            errors++;
            $display("FAIL rmid_clear: got v=%b busy=%b %h want 0 0 0", res_valid, busy, got);
        end
        checks++;
        if (done_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rmid_cnt: got %0d want 0", done_cnt);
        end
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_tie: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (res_valid !== 1'b1 || got !== e || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_res0: got v=%b %h r1=%b want v=1 %h r1=1",
                     res_valid, got, req1_ready, e);
        end
        exp_done++;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (res_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL rmid_res1: got v=%b %h want v=1 %h", res_valid, got, e);
        end
        exp_done++;
        @(negedge clk);
        checks++;
        if (done_cnt !== 16'(exp_done) || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_end: got cnt=%0d busy=%b want %0d 0", done_cnt, busy, exp_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
